// File: rtl/fetch2.sv
// Second fetch stage: issues 64-bit aligned imem reads and buffers the returned
// instruction pairs as fetch packets in a credit-protected FIFO for decode.
module fetch2 #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic [XLEN-1:0]   pc_i,
  input  logic              pc_valid_i,
  output logic              stall_o,
  input  logic              flush_i,
  output logic              imem_req_o,
  output logic [XLEN-1:0]   imem_addr_o,
  input  logic [2*XLEN-1:0] imem_rdata_i,
  output logic              dec_valid_o,
  input  logic              dec_ready_i,
  output logic [XLEN-1:0]   dec_pc_o,
  output logic [XLEN-1:0]   dec_instr0_o,
  output logic [XLEN-1:0]   dec_instr1_o,
  output logic [1:0]        dec_mask_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic            req_valid_q;
  logic [XLEN-1:0] req_pc_q;

  logic [XLEN-1:0] fifo_pc    [DEPTH];
  logic [XLEN-1:0] fifo_instr0[DEPTH];
  logic [XLEN-1:0] fifo_instr1[DEPTH];
  logic [1:0]      fifo_mask  [DEPTH];

  logic accept, push, pop;
  logic [XLEN-1:0] push_pc;
  logic [1:0]      push_mask;

  // Credit check uses registered state only; a same-cycle pop is not counted.
  assign stall_o     = (count_q + CW'(req_valid_q)) >= CW'(DEPTH);
  assign accept      = pc_valid_i & ~stall_o & ~flush_i;
  assign imem_req_o  = accept & reset_ni;
  assign imem_addr_o = {pc_i[XLEN-1:3], 3'b000};

  assign push      = req_valid_q & ~flush_i;
  assign dec_valid_o = (count_q != '0);
  assign pop       = dec_valid_o & dec_ready_i & ~flush_i;
  assign push_pc   = {req_pc_q[XLEN-1:3], 3'b000};
  assign push_mask = req_pc_q[2] ? 2'b10 : 2'b11;

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      if (push && !pop) count_d = count_q + CW'(1);
      if (!push && pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
    end else begin
      count_q     <= count_d;
      req_valid_q <= accept;
      req_pc_q    <= pc_i;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Packet storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clock_i) begin
    if (push) begin
      fifo_pc[wr_ptr_q]     <= push_pc;
      fifo_instr0[wr_ptr_q] <= imem_rdata_i[XLEN-1:0];
      fifo_instr1[wr_ptr_q] <= imem_rdata_i[2*XLEN-1:XLEN];
      fifo_mask[wr_ptr_q]   <= push_mask;
    end
  end

  assign dec_pc_o     = fifo_pc[rd_ptr_q];
  assign dec_instr0_o = fifo_instr0[rd_ptr_q];
  assign dec_instr1_o = fifo_instr1[rd_ptr_q];
  assign dec_mask_o   = fifo_mask[rd_ptr_q];

endmodule

// File: tb/tb_fetch2.sv
// Directed bench for fetch2: latency, odd-word entry, stall/credit, streaming,
// flush and asynchronous reset, with a memory returning {addr+4, addr}.
module tb_fetch2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_valid;
  logic        stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [63:0] imem_rdata = '0;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr0;
  logic [31:0] dec_instr1;
  logic [1:0]  dec_mask;

  int errors = 0;
  int checks = 0;

  fetch2 #(.DEPTH(4), .XLEN(32)) dut (
    .clock_i      (clk),
    .reset_ni     (rst_n),
    .pc_i         (pc),
    .pc_valid_i   (pc_valid),
    .stall_o      (stall),
    .flush_i      (flush),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_rdata_i (imem_rdata),
    .dec_valid_o  (dec_valid),
    .dec_ready_i  (dec_ready),
    .dec_pc_o     (dec_pc),
    .dec_instr0_o (dec_instr0),
    .dec_instr1_o (dec_instr1),
    .dec_mask_o   (dec_mask)
  );

  always #5 clk = ~clk;

  // Memory model: data for the address presented this cycle arrives next cycle.
  always @(posedge clk) imem_rdata <= {imem_addr + 32'd4, imem_addr};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; pc = '0; pc_valid = 1'b0; flush = 1'b0; dec_ready = 1'b0;
    cyc(); cyc();
    pc_valid = 1'b1; #1;
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    pc_valid = 1'b0;
    rst_n = 1'b1;
    cyc();

    // Three sequential requests, then drain in order.
    pc = 32'h0; pc_valid = 1'b1; #1;
    chk("t1_req0", 32'(imem_req), 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_valid_n0", 32'(dec_valid), 32'd0);
    cyc(); pc = 32'h8; #1;
    chk("t1_addr1", imem_addr, 32'h8);
    chk("t1_valid_n1", 32'(dec_valid), 32'd0);
    cyc(); pc = 32'h10; #1;
    chk("t1_addr2", imem_addr, 32'h10);
    chk("t1_valid_n2", 32'(dec_valid), 32'd1);
    chk("t1_pc0", dec_pc, 32'h0);
    chk("t1_i0_0", dec_instr0, 32'h0);
    chk("t1_i1_0", dec_instr1, 32'h4);
    chk("t1_mask0", 32'(dec_mask), 32'd3);
    cyc(); pc_valid = 1'b0;
    cyc();
    dec_ready = 1'b1; #1;
    chk("t1_pop_pc0", dec_pc, 32'h0);
    cyc();
    chk("t1_pop_pc1", dec_pc, 32'h8);
    chk("t1_pop_i1_1", dec_instr1, 32'hc);
    cyc();
    chk("t1_pop_pc2", dec_pc, 32'h10);
    chk("t1_pop_i0_2", dec_instr0, 32'h10);
    chk("t1_pop_mask2", 32'(dec_mask), 32'd3);
    cyc();
    chk("t1_empty", 32'(dec_valid), 32'd0);
    dec_ready = 1'b0;

    // Odd-word entry point.
    pc = 32'h104; pc_valid = 1'b1; #1;
    chk("t2_req", 32'(imem_req), 32'd1);
    chk("t2_addr", imem_addr, 32'h100);
    cyc(); pc_valid = 1'b0;
    cyc();
    chk("t2_valid", 32'(dec_valid), 32'd1);
    chk("t2_pc", dec_pc, 32'h100);
    chk("t2_i0", dec_instr0, 32'h100);
    chk("t2_i1", dec_instr1, 32'h104);
    chk("t2_mask", 32'(dec_mask), 32'd2);
    dec_ready = 1'b1;
    cyc(); dec_ready = 1'b0; #1;
    chk("t2_empty", 32'(dec_valid), 32'd0);

    // Fill to DEPTH with decode stalled.
    for (int i = 0; i < 4; i++) begin
      pc = 32'h40 + 32'(8 * i); pc_valid = 1'b1; #1;
      chk($sformatf("t3_req%0d", i), 32'(imem_req), 32'd1);
      chk($sformatf("t3_nostall%0d", i), 32'(stall), 32'd0);
      cyc();
    end
    pc = 32'h60;
    chk("t3_stall_a", 32'(stall), 32'd1);
    chk("t3_noreq_a", 32'(imem_req), 32'd0);
    cyc();
    chk("t3_stall_b", 32'(stall), 32'd1);
    chk("t3_noreq_b", 32'(imem_req), 32'd0);
    chk("t3_full_valid", 32'(dec_valid), 32'd1);
    cyc();
    chk("t3_stall_c", 32'(stall), 32'd1);
    pc_valid = 1'b0; dec_ready = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_drain_pc%0d", i), dec_pc, 32'h40 + 32'(8 * i));
      cyc();
    end
    chk("t3_drained", 32'(dec_valid), 32'd0);
    chk("t3_unstall", 32'(stall), 32'd0);

    // Steady stream with simultaneous push/pop, pointers wrapping.
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        pc = 32'h80 + 32'(8 * i); pc_valid = 1'b1;
      end else begin
        pc_valid = 1'b0;
      end
      #1;
      if (i < 6) chk($sformatf("t4_req%0d", i), 32'(imem_req), 32'd1);
      if (i >= 2) begin
        chk($sformatf("t4_valid%0d", i), 32'(dec_valid), 32'd1);
        chk($sformatf("t4_pc%0d", i), dec_pc, 32'h80 + 32'(8 * (i - 2)));
      end
      chk($sformatf("t4_stall%0d", i), 32'(stall), 32'd0);
      cyc();
    end
    chk("t4_empty", 32'(dec_valid), 32'd0);
    dec_ready = 1'b0;

    // Flush with 3 buffered and one in flight.
    for (int i = 0; i < 4; i++) begin
      pc = 32'h300 + 32'(8 * i); pc_valid = 1'b1;
      cyc();
    end
    pc = 32'h320; flush = 1'b1; #1;
    chk("t5_flush_noreq", 32'(imem_req), 32'd0);
    chk("t5_pre_valid", 32'(dec_valid), 32'd1);
    chk("t5_pre_stall", 32'(stall), 32'd1);
    cyc(); flush = 1'b0; pc_valid = 1'b0; #1;
    chk("t5_post_valid", 32'(dec_valid), 32'd0);
    chk("t5_post_stall", 32'(stall), 32'd0);
    cyc();
    chk("t5_inflight_dropped", 32'(dec_valid), 32'd0);
    pc = 32'h200; pc_valid = 1'b1; #1;
    chk("t5_new_req", 32'(imem_req), 32'd1);
    cyc(); pc_valid = 1'b0;
    cyc();
    chk("t5_new_valid", 32'(dec_valid), 32'd1);
    chk("t5_new_pc", dec_pc, 32'h200);
    dec_ready = 1'b1;
    cyc(); dec_ready = 1'b0;

    // Asynchronous reset between edges.
    pc = 32'h400; pc_valid = 1'b1;
    cyc(); pc = 32'h408;
    cyc(); pc = 32'h410; #1;
    chk("t6_pre_req", 32'(imem_req), 32'd1);
    chk("t6_pre_valid", 32'(dec_valid), 32'd1);
    #2 rst_n = 1'b0; #1;
    chk("t6_rst_valid", 32'(dec_valid), 32'd0);
    chk("t6_rst_stall", 32'(stall), 32'd0);
    chk("t6_rst_req", 32'(imem_req), 32'd0);
    cyc();
    rst_n = 1'b1; pc = 32'h500; #1;
    chk("t6_first_req", 32'(imem_req), 32'd1);
    chk("t6_first_addr", imem_addr, 32'h500);
    cyc(); pc_valid = 1'b0;
    cyc();
    chk("t6_first_valid", 32'(dec_valid), 32'd1);
    chk("t6_first_pc", dec_pc, 32'h500);
    chk("t6_first_i1", dec_instr1, 32'h504);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
